// File: rtl/tlk2711_axil_regbus.sv
// AXI4-Lite slave bridging to the TLK2711 channel register bus.
// One transaction in flight; writes take priority over a colliding read.
module tlk2711_axil_regbus #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                ps_clk,
    input  logic                ps_rst_n,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [ADDR_W-1:0]   s_axil_awaddr,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    input  logic [DATA_W-1:0]   s_axil_wdata,
    input  logic [DATA_W/8-1:0] s_axil_wstrb,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    output logic [1:0]          s_axil_bresp,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    input  logic [ADDR_W-1:0]   s_axil_araddr,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic [DATA_W-1:0]   s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                o_reg_wen,
    output logic [15:0]         o_reg_waddr,
    output logic [63:0]         o_reg_wdata,
    output logic                o_reg_ren,
    output logic [15:0]         o_reg_raddr,
    input  logic [63:0]         i_reg_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] LAT         = 3'(RD_LATENCY);

    typedef enum logic [2:0] {StIdle, StWrIssue, StWrResp, StRdWait, StRdResp} state_t;

    state_t                r_state, w_state;
    logic                  r_aw_full, w_aw_full, r_w_full, w_w_full;
    logic [ADDR_W-1:0]     r_awaddr, w_awaddr, r_araddr, w_araddr;
    logic [DATA_W-1:0]     r_wdata, w_wdata;
    logic [DATA_W/8-1:0]   r_wstrb, w_wstrb;
    logic                  r_ar_pend, w_ar_pend, r_rd_err, w_rd_err;
    logic [2:0]            r_cnt, w_cnt;
    logic                  r_awready, w_awready, r_wready, w_wready, r_arready, w_arready;
    logic                  r_bvalid, w_bvalid, r_rvalid, w_rvalid;
    logic [1:0]            r_bresp, w_bresp, r_rresp, w_rresp;
    logic [DATA_W-1:0]     r_rdata, w_rdata;
    logic                  r_wen, w_wen, r_ren, w_ren;
    logic [15:0]           r_waddr, w_waddr, r_raddr, w_raddr;
    logic [63:0]           r_wdo, w_wdo;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_pair_now, w_rd_go;
    logic [ADDR_W-1:0]     w_rd_addr;

    assign w_aw_hs = s_axil_awvalid && r_awready;
    assign w_w_hs  = s_axil_wvalid && r_wready;
    assign w_ar_hs = s_axil_arvalid && r_arready;

    always_comb begin
        w_state   = r_state;
        w_aw_full = r_aw_full | w_aw_hs;
        w_awaddr  = w_aw_hs ? s_axil_awaddr : r_awaddr;
        w_w_full  = r_w_full | w_w_hs;
        w_wdata   = w_w_hs ? s_axil_wdata : r_wdata;
        w_wstrb   = w_w_hs ? s_axil_wstrb : r_wstrb;
        w_ar_pend = r_ar_pend;
        w_araddr  = r_araddr;
        w_rd_err  = r_rd_err;
        w_cnt     = r_cnt;
        w_bvalid  = r_bvalid;
        w_bresp   = r_bresp;
        w_rvalid  = r_rvalid;
        w_rresp   = r_rresp;
        w_rdata   = r_rdata;
        w_wen     = 1'b0;
        w_waddr   = r_waddr;
        w_wdo     = r_wdo;
        w_ren     = 1'b0;
        w_raddr   = r_raddr;
        w_pair_now = w_aw_full && w_w_full;
        w_rd_go   = 1'b0;
        w_rd_addr = s_axil_araddr;

        unique case (r_state)
            StIdle: begin
                if (r_aw_full && r_w_full) begin
                    w_state = StWrIssue;
                    if ((&r_wstrb) && (r_awaddr[2:0] == 3'b000)) begin
                        w_wen   = 1'b1;
                        w_waddr = 16'(r_awaddr);
                        w_wdo   = 64'(r_wdata);
                        w_bresp = RESP_OKAY;
                    end else begin
                        w_bresp = RESP_SLVERR;
                    end
                end else if (w_ar_hs && w_pair_now) begin
                    // Read accepted as the write pair completes: park it behind the write.
                    w_ar_pend = 1'b1;
                    w_araddr  = s_axil_araddr;
                end else if (w_ar_hs || r_ar_pend) begin
                    w_rd_go   = 1'b1;
                    w_rd_addr = r_ar_pend ? r_araddr : s_axil_araddr;
                end
            end
            StWrIssue: begin
                w_state  = StWrResp;
                w_bvalid = 1'b1;
            end
            StWrResp: begin
                if (s_axil_bready) begin
                    w_bvalid  = 1'b0;
                    w_aw_full = 1'b0;
                    w_w_full  = 1'b0;
                    w_state   = StIdle;
                end
            end
            StRdWait: begin
                if (r_cnt == LAT) begin
                    w_rdata = r_rd_err ? '0 : DATA_W'(i_reg_rdata);
                    w_state = StRdResp;
                end else begin
                    w_cnt = r_cnt + 3'd1;
                end
            end
            StRdResp: begin
                if (!r_rvalid) begin
                    w_rvalid = 1'b1;
                end else if (s_axil_rready) begin
                    w_rvalid = 1'b0;
                    w_state  = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase

        if (w_rd_go) begin
            w_state   = StRdWait;
            w_cnt     = 3'd0;
            w_ar_pend = 1'b0;
            w_rd_err  = (w_rd_addr[2:0] != 3'b000);
            w_rresp   = w_rd_err ? RESP_SLVERR : RESP_OKAY;
            if (!w_rd_err) begin
                w_ren   = 1'b1;
                w_raddr = 16'(w_rd_addr);
            end
        end

        w_awready = (w_state == StIdle) && !w_aw_full;
        w_wready  = (w_state == StIdle) && !w_w_full;
        w_arready = (w_state == StIdle) && !(w_aw_full && w_w_full) && !w_ar_pend;
    end

    always_ff @(posedge ps_clk) begin
        if (!ps_rst_n) begin
            r_state   <= StIdle;
            r_aw_full <= 1'b0;
            r_awaddr  <= '0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_ar_pend <= 1'b0;
            r_araddr  <= '0;
            r_rd_err  <= 1'b0;
            r_cnt     <= 3'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_wen     <= 1'b0;
            r_waddr   <= 16'd0;
            r_wdo     <= 64'd0;
            r_ren     <= 1'b0;
            r_raddr   <= 16'd0;
        end else begin
            r_state   <= w_state;
            r_aw_full <= w_aw_full;
            r_awaddr  <= w_awaddr;
            r_w_full  <= w_w_full;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_ar_pend <= w_ar_pend;
            r_araddr  <= w_araddr;
            r_rd_err  <= w_rd_err;
            r_cnt     <= w_cnt;
            r_awready <= w_awready;
            r_wready  <= w_wready;
            r_arready <= w_arready;
            r_bvalid  <= w_bvalid;
            r_bresp   <= w_bresp;
            r_rvalid  <= w_rvalid;
            r_rresp   <= w_rresp;
            r_rdata   <= w_rdata;
            r_wen     <= w_wen;
            r_waddr   <= w_waddr;
            r_wdo     <= w_wdo;
            r_ren     <= w_ren;
            r_raddr   <= w_raddr;
        end
    end

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_arready = r_arready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;
    assign o_reg_wen      = r_wen;
    assign o_reg_waddr    = r_waddr;
    assign o_reg_wdata    = r_wdo;
    assign o_reg_ren      = r_ren;
    assign o_reg_raddr    = r_raddr;

endmodule

// File: doc/tlk2711_axil_regbus.md
TLK2711_AXIL_REGBUS -- requirements
Module: tlk2711_axil_regbus

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, register-bus byte address width.
REQ-002 SHALL have parameter DATA_W, default 64, AXI4-Lite and register-bus data width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, cycles from o_reg_ren pulse to valid i_reg_rdata, legal range 1..7.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
- Ports, in order:
  - ps_clk  in  1  sole clock; all logic on rising edge.
  - ps_rst_n  in  1  synchronous active-low reset.
  - s_axil_awvalid/awready  in/out  1  write-address handshake.
  - s_axil_awaddr  in  ADDR_W  write byte address.
  - s_axil_wvalid/wready  in/out  1  write-data handshake.
  - s_axil_wdata  in  DATA_W  write data.
  - s_axil_wstrb  in  DATA_W/8  byte strobes.
  - s_axil_bvalid/bready  out/in  1  write-response handshake.
  - s_axil_bresp  out  2  00 OKAY, 10 SLVERR.
  - s_axil_arvalid/arready  in/out  1  read-address handshake.
  - s_axil_araddr  in  ADDR_W  read byte address.
  - s_axil_rvalid/rready  out/in  1  read-data handshake.
  - s_axil_rdata  out  DATA_W  read data.
  - s_axil_rresp  out  2  read response.
  - o_reg_wen  out  1  one-cycle register write strobe.
  - o_reg_waddr  out  16  register write address.
  - o_reg_wdata  out  64  register write data.
  - o_reg_ren  out  1  one-cycle register read strobe.
  - o_reg_raddr  out  16  register read address.
  - i_reg_rdata  in  64  OR-combined read data from both TLK2711 channel register files.

Function
REQ-005 SHALL implement FSM states IDLE, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP; one transaction in flight at a time.
REQ-006 SHALL accept AW and W independently in any order, each into its own holding register; awready high only while the AW holder is empty, wready high only while the W holder is empty, neither accepted outside IDLE.
REQ-007 SHALL, in IDLE with both AW and W holders full, go to WR_ISSUE.
REQ-008 SHALL, in WR_ISSUE, pulse o_reg_wen for exactly one cycle with the held address and data, but only if wstrb is all ones and awaddr[2:0]==0; otherwise SHALL issue no strobe and set bresp=SLVERR. Then go to WR_RESP.
REQ-009 SHALL, in WR_RESP, hold bvalid high with bresp stable until bready; on the handshake, clear both holders and return to IDLE.
REQ-010 SHALL assert arready only in IDLE while the AW and W holders are both empty or incomplete (no pending write pair); on an AR handshake, drive o_reg_raddr and pulse o_reg_ren the same cycle, then go to RD_WAIT.
REQ-011 SHALL, when an AR handshake and write-pair completion coincide in IDLE, serve the write first (arready low that cycle).
REQ-012 SHALL count RD_LATENCY cycles in RD_WAIT, then capture i_reg_rdata into rdata and go to RD_RESP.
REQ-013 SHALL set rresp=SLVERR and rdata=0 for misaligned araddr (araddr[2:0]!=0); the read still takes the RD_WAIT path but o_reg_ren is not pulsed.
REQ-014 SHALL, in RD_RESP, hold rvalid, rdata and rresp stable until rready; on the handshake, return to IDLE.
REQ-015 SHALL hold o_reg_waddr/o_reg_raddr at their last values when no strobe is active; address bits above 15 SHALL be truncated.
REQ-016 SHALL register all outputs, with no combinational path from any AXI input to any AXI ready/valid output.
REQ-017 SHALL give a latency of 2 cycles from completion of the second write handshake (AW or W) to bvalid, and 1+RD_LATENCY+1 cycles from the AR handshake to rvalid.

Reset
REQ-018 SHALL, while ps_rst_n=0 on a clock edge, force state=IDLE and clear both holders, the read counter, awready, wready, arready, bvalid, rvalid, o_reg_wen, o_reg_ren, bresp, rresp, rdata, o_reg_waddr, o_reg_raddr and o_reg_wdata.
REQ-019 SHALL abandon any in-flight transaction on reset, with no o_reg_wen/o_reg_ren pulse in the cycle after reset release.
REQ-020 SHALL raise awready, wready and arready in the first cycle after release.

Verification
REQ-021 Write: AW 0x0108 first, W 0x1122334455667788 three cycles later, wstrb 0xFF -> one o_reg_wen pulse with waddr 0x0108 and that data; bvalid 2 cycles after the W handshake, bresp 00.
REQ-022 Read: AR 0x0010, RD_LATENCY=1, model returns 0xDEADBEEF00000001 one cycle after ren -> rdata equals it, rresp 00, rvalid 3 cycles after the AR handshake.
REQ-023 Errors: wstrb 0x0F -> no o_reg_wen, bresp 10; araddr 0x0004 -> no o_reg_ren, rresp 10, rdata 0.
REQ-024 Backpressure: bready/rready held low 10 cycles -> valid and payload stable; no new awready/arready until the handshake completes.
REQ-025 Collision: AR arrives the same cycle the write pair completes -> write is issued first, then the read; exactly one wen and one ren.
REQ-026 Reset mid-read, during RD_WAIT -> rvalid never asserts; after release, a read of 0x0100 completes normally.
